// File: rtl/game_state_manager.sv
`default_nettype none
// ============================================================================
//  Module      : game_state_manager
//  Description : Consumes per-frame collision single-hit pulses and maintains
//                lives, score, level and damage invulnerability; sequences
//                play, level completion, game over and win.
//                Optional feature macro: LIFE_BONUS_EN (extra life on every
//                100-point score crossing).
//  Revision    : 1.0 - initial release
// ============================================================================
module game_state_manager #(
    parameter int INIT_LIVES         = 3,
    parameter int MAX_LIVES          = 5,
    parameter int SCORE_W            = 12,
    parameter int DIAMOND_PTS        = 10,
    parameter int KILL_PTS           = 5,
    parameter int INVULN_FRAMES      = 60,
    parameter int NUM_LEVELS         = 3,
    parameter int LEVEL_PAUSE_FRAMES = 90
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               start_key,
    input  logic               SHP_bumpyDiamond,
    input  logic               SHP_bumpyHeart,
    input  logic               SHP_bumpyObstacle,
    input  logic               SHP_bumpyCovid,
    input  logic               SHP_bumpyFinishFlag,
    input  logic               SHP_shootObstacle,
    input  logic               SHP_shootCovid,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         level,
    output logic [1:0]         state,
    output logic               invulnerable,
    output logic               blink,
    output logic               level_load,
    output logic               game_over,
    output logic               game_won
);

    // Counter widths; the invulnerability counter needs at least bit 2 for blink
    localparam int c_invW   = ($clog2(INVULN_FRAMES + 1) < 3) ? 3 : $clog2(INVULN_FRAMES + 1);
    localparam int c_pauseW = ($clog2(LEVEL_PAUSE_FRAMES + 1) < 1) ? 1 : $clog2(LEVEL_PAUSE_FRAMES + 1);
    // Headroom so one cycle of additions can never wrap before saturation
    localparam int c_sumW   = SCORE_W + 8;

    localparam logic [c_sumW-1:0]   c_scoreMax   = c_sumW'({SCORE_W{1'b1}});
    localparam logic [2:0]          c_initLives  = 3'(INIT_LIVES);
    localparam logic [2:0]          c_maxLives   = 3'(MAX_LIVES);
    localparam logic [1:0]          c_lastLevel  = 2'(NUM_LEVELS - 1);
    localparam logic [c_invW-1:0]   c_invLoad    = c_invW'(INVULN_FRAMES);
    localparam logic [c_pauseW-1:0] c_pauseLoad  = c_pauseW'(LEVEL_PAUSE_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_PLAY       = 2'd1,
        S_LEVEL_DONE = 2'd2,
        S_END        = 2'd3
    } stateT;

    stateT               r_state;
    logic [2:0]          r_lives;
    logic [SCORE_W-1:0]  r_score;
    logic [1:0]          r_level;
    logic                r_invulnerable;
    logic [c_invW-1:0]   r_invCnt;
    logic [c_pauseW-1:0] r_pauseCnt;
    logic                r_levelLoad;
    logic                r_gameOver;
    logic                r_gameWon;

    logic                w_hit;
    logic                w_heart;
    logic [c_sumW-1:0]   w_scoreSum;
    logic [SCORE_W-1:0]  w_scoreNext;
    logic [2:0]          w_livesDH;
    logic [2:0]          w_livesNext;
    logic [c_invW-1:0]   w_invCntNext;
    logic                w_invulnNext;

    // Finish flag dominates damage and heart; damage needs the shield down
    assign w_hit   = (SHP_bumpyObstacle | SHP_bumpyCovid) & ~r_invulnerable & ~SHP_bumpyFinishFlag;
    assign w_heart = SHP_bumpyHeart & ~SHP_bumpyFinishFlag;

    assign w_scoreSum = c_sumW'(r_score)
                      + (SHP_bumpyDiamond  ? c_sumW'(DIAMOND_PTS) : '0)
                      + (SHP_shootObstacle ? c_sumW'(KILL_PTS)    : '0)
                      + (SHP_shootCovid    ? c_sumW'(KILL_PTS)    : '0);
    assign w_scoreNext = (w_scoreSum > c_scoreMax) ? c_scoreMax[SCORE_W-1:0] : w_scoreSum[SCORE_W-1:0];

    // Lives after damage/heart: a hit together with a heart nets to zero
    always_comb begin
        w_livesDH = r_lives;
        if (w_hit) begin
            if (!w_heart) begin
                w_livesDH = r_lives - 3'd1;
            end
        end else if (w_heart && (r_lives < c_maxLives)) begin
            w_livesDH = r_lives + 3'd1;
        end
    end

`ifdef LIFE_BONUS_EN
    logic [c_sumW-1:0] r_nextThresh;
    logic              w_bonus;

    assign w_bonus     = (c_sumW'(w_scoreNext) >= r_nextThresh);
    assign w_livesNext = (w_bonus && (w_livesDH < c_maxLives)) ? (w_livesDH + 3'd1) : w_livesDH;

    // Next 100-point threshold; advances by one step per award
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nextThresh <= c_sumW'(100);
        end else if ((r_state == S_IDLE) && start_key) begin
            r_nextThresh <= c_sumW'(100);
        end else if ((r_state == S_PLAY) && w_bonus) begin
            r_nextThresh <= r_nextThresh + c_sumW'(100);
        end
    end
`else
    assign w_livesNext = w_livesDH;
`endif

    // Free-running shield decay: count frames down, drop the shield one cycle after zero
    always_comb begin
        w_invCntNext = r_invCnt;
        w_invulnNext = r_invulnerable;
        if (r_invulnerable) begin
            if (r_invCnt == '0) begin
                w_invulnNext = 1'b0;
            end else if (startOfFrame) begin
                w_invCntNext = r_invCnt - c_invW'(1);
            end
        end
    end

    // Main game FSM with all game-state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_lives        <= c_initLives;
            r_score        <= '0;
            r_level        <= '0;
            r_invulnerable <= 1'b0;
            r_invCnt       <= '0;
            r_pauseCnt     <= '0;
            r_levelLoad    <= 1'b0;
            r_gameOver     <= 1'b0;
            r_gameWon      <= 1'b0;
        end else begin
            r_levelLoad <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_key) begin
                        r_lives        <= c_initLives;
                        r_score        <= '0;
                        r_level        <= '0;
                        r_invulnerable <= 1'b0;
                        r_invCnt       <= '0;
                        r_pauseCnt     <= '0;
                        r_gameOver     <= 1'b0;
                        r_gameWon      <= 1'b0;
                        r_levelLoad    <= 1'b1;
                        r_state        <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    r_score <= w_scoreNext;
                    r_lives <= w_livesNext;
                    if (w_hit) begin
                        r_invulnerable <= 1'b1;
                        r_invCnt       <= c_invLoad;
                    end else begin
                        r_invulnerable <= w_invulnNext;
                        r_invCnt       <= w_invCntNext;
                    end
                    if (SHP_bumpyFinishFlag) begin
                        if (r_level == c_lastLevel) begin
                            r_gameWon <= 1'b1;
                            r_state   <= S_END;
                        end else begin
                            r_pauseCnt <= c_pauseLoad;
                            r_state    <= S_LEVEL_DONE;
                        end
                    end else if (w_hit && (w_livesNext == 3'd0)) begin
                        r_gameOver <= 1'b1;
                        r_state    <= S_END;
                    end
                end
                S_LEVEL_DONE: begin
                    r_invulnerable <= w_invulnNext;
                    r_invCnt       <= w_invCntNext;
                    if (startOfFrame) begin
                        if (r_pauseCnt <= c_pauseW'(1)) begin
                            r_pauseCnt     <= '0;
                            r_level        <= r_level + 2'd1;
                            r_levelLoad    <= 1'b1;
                            r_invulnerable <= 1'b0;
                            r_invCnt       <= '0;
                            r_state        <= S_PLAY;
                        end else begin
                            r_pauseCnt <= r_pauseCnt - c_pauseW'(1);
                        end
                    end
                end
                S_END: begin
                    // Only a return to IDLE; a held key cannot restart play directly
                    if (start_key) begin
                        r_gameOver <= 1'b0;
                        r_gameWon  <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign lives        = r_lives;
    assign score        = r_score;
    assign level        = r_level;
    assign state        = r_state;
    assign invulnerable = r_invulnerable;
    assign blink        = r_invulnerable & r_invCnt[2];
    assign level_load   = r_levelLoad;
    assign game_over    = r_gameOver;
    assign game_won     = r_gameWon;

endmodule
`default_nettype wire

// File: tb/tb_game_state_manager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_state_manager
//  Description : Directed self-checking bench for game_state_manager.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_state_manager;

    logic        clk = 1'b0;
    logic        reset;
    logic        startOfFrame;
    logic        start_key;
    logic        SHP_bumpyDiamond;
    logic        SHP_bumpyHeart;
    logic        SHP_bumpyObstacle;
    logic        SHP_bumpyCovid;
    logic        SHP_bumpyFinishFlag;
    logic        SHP_shootObstacle;
    logic        SHP_shootCovid;
    logic [2:0]  lives;
    logic [11:0] score;
    logic [1:0]  level;
    logic [1:0]  state;
    logic        invulnerable;
    logic        blink;
    logic        level_load;
    logic        game_over;
    logic        game_won;

    int errCnt = 0;
    int chkCnt = 0;

    game_state_manager dut (
        .clk                 (clk),
        .reset               (reset),
        .startOfFrame        (startOfFrame),
        .start_key           (start_key),
        .SHP_bumpyDiamond    (SHP_bumpyDiamond),
        .SHP_bumpyHeart      (SHP_bumpyHeart),
        .SHP_bumpyObstacle   (SHP_bumpyObstacle),
        .SHP_bumpyCovid      (SHP_bumpyCovid),
        .SHP_bumpyFinishFlag (SHP_bumpyFinishFlag),
        .SHP_shootObstacle   (SHP_shootObstacle),
        .SHP_shootCovid      (SHP_shootCovid),
        .lives               (lives),
        .score               (score),
        .level               (level),
        .state               (state),
        .invulnerable        (invulnerable),
        .blink               (blink),
        .level_load          (level_load),
        .game_over           (game_over),
        .game_won            (game_won)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
        end
    endtask

    task automatic startPulse();
        start_key = 1'b1;
        tick();
        start_key = 1'b0;
    endtask

    task automatic diamond();
        SHP_bumpyDiamond = 1'b1;
        tick();
        SHP_bumpyDiamond = 1'b0;
    endtask

    task automatic hit();
        SHP_bumpyObstacle = 1'b1;
        tick();
        SHP_bumpyObstacle = 1'b0;
    endtask

    task automatic finish();
        SHP_bumpyFinishFlag = 1'b1;
        tick();
        SHP_bumpyFinishFlag = 1'b0;
    endtask

    initial begin
        reset = 1'b1; startOfFrame = 1'b0; start_key = 1'b0;
        SHP_bumpyDiamond = 1'b0; SHP_bumpyHeart = 1'b0; SHP_bumpyObstacle = 1'b0;
        SHP_bumpyCovid = 1'b0; SHP_bumpyFinishFlag = 1'b0;
        SHP_shootObstacle = 1'b0; SHP_shootCovid = 1'b0;
        tick(); tick();
        check("rst_lives", lives, 3);
        check("rst_score", score, 0);
        check("rst_level", level, 0);
        check("rst_state", state, 0);
        check("rst_invuln", invulnerable, 0);
        check("rst_blink", blink, 0);
        check("rst_load", level_load, 0);
        check("rst_over", game_over, 0);
        check("rst_won", game_won, 0);
        reset = 1'b0;
        tick();

        // Start game
        startPulse();
        check("start_load", level_load, 1);
        check("start_state", state, 1);
        check("start_lives", lives, 3);
        check("start_score", score, 0);
        check("start_level", level, 0);
        tick();
        check("start_load_drop", level_load, 0);

        // Scoring
        diamond();
        check("score_d1", score, 10);
        diamond(); diamond();
        SHP_shootObstacle = 1'b1; SHP_shootCovid = 1'b1;
        tick();
        SHP_shootObstacle = 1'b0; SHP_shootCovid = 1'b0;
        check("score_40", score, 40);

        // Damage and invulnerability window
        hit();
        check("hit1_lives", lives, 2);
        check("hit1_invuln", invulnerable, 1);
        check("hit1_blink", blink, 1);        // counter 60 -> bit2 set
        frames(10);
        check("blink_50", blink, 0);          // counter 50 -> bit2 clear
        SHP_bumpyCovid = 1'b1; tick(); SHP_bumpyCovid = 1'b0;
        check("hit2_ignored", lives, 2);
        frames(51);
        check("invuln_expired", invulnerable, 0);
        hit();
        check("hit3_lives", lives, 1);

        // Hearts saturate
        SHP_bumpyHeart = 1'b1;
        repeat (5) tick();
        SHP_bumpyHeart = 1'b0;
        check("heart_sat", lives, 5);
        frames(61);
        check("invuln_off2", invulnerable, 0);
        SHP_bumpyObstacle = 1'b1; SHP_bumpyHeart = 1'b1;
        tick();
        SHP_bumpyObstacle = 1'b0; SHP_bumpyHeart = 1'b0;
        check("dmg_heart_lives", lives, 5);
        check("dmg_heart_invuln", invulnerable, 1);

        // Level completion
        finish();
        check("ld_state", state, 2);
        frames(89);
        check("ld_hold", state, 2);
        frames(1);
        check("ld_exit_state", state, 1);
        check("ld_exit_level", level, 1);
        check("ld_exit_load", level_load, 1);
        check("ld_exit_invuln", invulnerable, 0);
        tick();
        check("ld_load_drop", level_load, 0);
        finish();
        frames(90);
        check("level2", level, 2);
        finish();
        check("won_state", state, 3);
        check("won_flag", game_won, 1);
        check("won_over", game_over, 0);
        diamond();
        check("end_hold_score", score, 40);

        // Restart path through IDLE
        startPulse();
        check("end_to_idle", state, 0);
        check("idle_won_clr", game_won, 0);
        startPulse();
        check("restart_state", state, 1);
        check("restart_score", score, 0);
        check("restart_lives", lives, 3);

        // Finish beats damage in the same cycle
        SHP_bumpyFinishFlag = 1'b1; SHP_bumpyObstacle = 1'b1;
        tick();
        SHP_bumpyFinishFlag = 1'b0; SHP_bumpyObstacle = 1'b0;
        check("fin_dmg_state", state, 2);
        check("fin_dmg_lives", lives, 3);
        frames(90);
        check("fin_dmg_level", level, 1);

        // Game over
        hit(); frames(61);
        hit(); frames(61);
        check("pre_over_lives", lives, 1);
        hit();
        check("over_lives", lives, 0);
        check("over_state", state, 3);
        check("over_flag", game_over, 1);

        // Asynchronous reset during LEVEL_DONE
        startPulse(); startPulse();
        diamond();
        finish();
        check("pre_rst_state", state, 2);
        #3;
        reset = 1'b1;
        #1;
        check("arst_state", state, 0);
        check("arst_score", score, 0);
        check("arst_lives", lives, 3);
        check("arst_load", level_load, 0);
        check("arst_over", game_over, 0);
        tick();
        reset = 1'b0;
        tick();

        // Score crossing 100, then saturation
        startPulse();
        SHP_bumpyDiamond = 1'b1;
        repeat (9) tick();
        SHP_bumpyDiamond = 1'b0;
        SHP_shootObstacle = 1'b1; tick(); SHP_shootObstacle = 1'b0;
        check("score_95", score, 95);
        diamond();
        check("score_105", score, 105);
`ifdef LIFE_BONUS_EN
        check("bonus_lives", lives, 4);
`else
        check("bonus_lives", lives, 3);
`endif
        SHP_bumpyDiamond = 1'b1;
        repeat (400) tick();
        SHP_bumpyDiamond = 1'b0;
        check("score_sat", score, 4095);
        SHP_bumpyDiamond = 1'b1; SHP_shootObstacle = 1'b1; SHP_shootCovid = 1'b1;
        tick();
        SHP_bumpyDiamond = 1'b0; SHP_shootObstacle = 1'b0; SHP_shootCovid = 1'b0;
        check("score_sat_hold", score, 4095);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_state_manager.md
Name: game_state_manager

Overview:
- Receiving end of the collision single-hit-pulse interface: consumes the per-frame collision pulses and turns them into game state.
- Holds lives, score, level and damage-invulnerability.
- Sequences play, level completion and game over.
- Feeds the HUD/score display, the Bumpy blink logic and the level loader.

Parameters:
- INIT_LIVES, 3, lives loaded at game start.
- MAX_LIVES, 5, life ceiling; heart pickups saturate here.
- SCORE_W, 12, score register width.
- DIAMOND_PTS, 10, points per Bumpy–diamond pulse.
- KILL_PTS, 5, points per shoot–obstacle or shoot–covid pulse.
- INVULN_FRAMES, 60, frames of damage immunity after a hit.
- NUM_LEVELS, 3, number of levels; completing the last one wins the game.
- LEVEL_PAUSE_FRAMES, 90, frames spent in LEVEL_DONE before the next level starts.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- startOfFrame, in, 1, one-cycle pulse per frame.
- start_key, in, 1, level-sensitive start request.
- SHP_bumpyDiamond, in, 1, pickup pulse.
- SHP_bumpyHeart, in, 1, pickup pulse.
- SHP_bumpyObstacle, in, 1, damage pulse.
- SHP_bumpyCovid, in, 1, damage pulse.
- SHP_bumpyFinishFlag, in, 1, level-end pulse.
- SHP_shootObstacle, in, 1, kill pulse.
- SHP_shootCovid, in, 1, kill pulse.
- lives, out, 3, remaining lives.
- score, out, SCORE_W, current score.
- level, out, 2, current level, 0-based.
- state, out, 2, encoded FSM state.
- invulnerable, out, 1, high while damage is ignored.
- blink, out, 1, toggles every 4 frames while invulnerable; 0 otherwise.
- level_load, out, 1, one-cycle pulse requesting a level reload.
- game_over, out, 1, high in GAME_OVER.
- game_won, out, 1, high in WON.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is asynchronous and active-high on port reset.
  - Reset values: lives=INIT_LIVES, score=0, level=0, state=IDLE, invulnerable=0, blink=0, level_load=0, game_over=0, game_won=0.
  - All internal counters reset to 0.
  - Reset asserted mid-game returns to IDLE immediately. No pulse is emitted during reset.
- FSM states: IDLE=0, PLAY=1, LEVEL_DONE=2, END=3. END covers GAME_OVER and WON, distinguished by game_over/game_won.
- IDLE:
  - start_key=1 loads lives=INIT_LIVES, score=0, level=0, pulses level_load for one cycle, and goes to PLAY.
- PLAY:
  - All SHP inputs are sampled every cycle; they are ignored in every other state.
  - Score: add DIAMOND_PTS×bumpyDiamond + KILL_PTS×(shootObstacle + shootCovid) in one cycle.
  - Score saturates at 2^SCORE_W−1 and never wraps.
  - Damage: (bumpyObstacle | bumpyCovid) while invulnerable=0 decrements lives by exactly 1, even if both pulses are high.
  - A damage hit also sets invulnerable=1 and loads the frame counter with INVULN_FRAMES.
  - Damage while invulnerable=1 is ignored.
  - Heart: bumpyHeart increments lives, saturating at MAX_LIVES.
  - Same-cycle priority: finish flag > damage > heart.
    - Finish flag with damage: damage is dropped, lives unchanged.
    - Damage with heart: net lives change is 0, and invulnerability still starts.
  - Score accumulation applies in the same cycle regardless of priority.
  - Damage that brings lives to 0 goes to END with game_over=1.
  - bumpyFinishFlag:
    - if level==NUM_LEVELS−1, go to END with game_won=1;
    - otherwise go to LEVEL_DONE and load the pause counter with LEVEL_PAUSE_FRAMES.
- Invulnerability counter:
  - Decrements on startOfFrame while nonzero.
  - invulnerable clears in the cycle after the counter reaches 0.
  - blink = bit 2 of the counter, gated by invulnerable.
- LEVEL_DONE:
  - Pause counter decrements on startOfFrame.
  - On reaching 0: level += 1, level_load pulses for one cycle, invulnerable is cleared, return to PLAY.
- END:
  - Holds all outputs.
  - start_key=1 goes to IDLE; it does not restart directly. This prevents a held key from re-entering play.
- Latency:
  - A pulse at cycle N is visible on lives/score/state at cycle N+1.
  - level_load is registered, 1 cycle after the triggering transition.

Optional Feature:
- Macro: LIFE_BONUS_EN.
- Defined:
  - Each time score crosses a multiple of 100, lives increments by 1, saturating at MAX_LIVES.
  - Implemented with an internal next-threshold register (reset 100, advanced by 100 on each award).
  - At most one award per cycle.
  - Applied after damage/heart in the same cycle.
- Undefined: no bonus logic is present and lives changes only through heart and damage pulses.

Test Plan:
- Reset, then start_key for 1 cycle -> level_load pulse, state=1, lives=3, score=0, level=0.
- In PLAY, 3 bumpyDiamond pulses plus 1 cycle with shootObstacle and shootCovid together -> score=40.
- bumpyObstacle, then bumpyCovid 10 frames later, then a third hit after 61 frames -> lives 3→2, second hit ignored, then 2→1. blink toggles while invulnerable=1.
- bumpyHeart 4 times from lives=3 -> lives=5, saturated. Damage and heart in the same cycle -> lives unchanged, invulnerable=1.
- bumpyFinishFlag at level 0 -> state=2. After 90 startOfFrame pulses -> level=1, level_load pulse, state=1. Finish at level 2 -> game_won=1, state=3.
- Lives=1 plus damage -> game_over=1. Assert reset mid-LEVEL_DONE -> all outputs at reset values. With LIFE_BONUS_EN: score 95→105 -> lives +1.
